// File: rtl/piso_shift_tx.sv
// ============================================================================
// piso_shift_tx : parallel-in/serial-out transmitter with valid/ready load.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int                 CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shreg_next;
  logic             out_bit;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  // Shift toward whichever end drives sout, zero-filling behind.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign out_bit    = shreg_q[WIDTH-1];
      assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign out_bit    = shreg_q[0];
      assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      if (state_q == IDLE && load) begin
        par_q <= ^din;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          shreg_d = din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = shreg_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; load/din never reach them directly.
  always_comb begin
    sout = 1'b0;
    case (state_q)
      SHIFT:   sout = out_bit;
`ifdef PISO_PARITY_EN
      PARITY:  sout = par_q;
`endif
      default: sout = 1'b0;
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign sout_valid = (state_q != IDLE);
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
// ============================================================================
// tb_piso_shift_tx : directed self-checking bench for piso_shift_tx (WIDTH=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_piso_shift_tx;

  logic       clk;
  logic       rs;
  logic [3:0] din_m, din_l;
  logic       load_m, load_l;
  logic       ready_m, sout_m, valid_m, done_m;
  logic       ready_l, sout_l, valid_l, done_l;

  int n_cmp;
  int n_err;

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rs(rs), .din(din_m), .load(load_m),
    .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
  );

  piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rs(rs), .din(din_l), .load(load_l),
    .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input bit sel, input logic [3:0] d, input logic l);
    if (sel) begin din_l = d; load_l = l; end
    else     begin din_m = d; load_m = l; end
  endtask

  task automatic check_outs(input bit sel, input string tag,
                            input logic s, input logic v, input logic r, input logic dn);
    check({tag, ".sout"},  sel ? sout_l  : sout_m,  s);
    check({tag, ".valid"}, sel ? valid_l : valid_m, v);
    check({tag, ".ready"}, sel ? ready_l : ready_m, r);
    check({tag, ".done"},  sel ? done_l  : done_m,  dn);
  endtask

  // Called right after the accepting edge; leaves the bench in the done cycle.
  // seq[3] is the first bit expected on the wire. At frame bit inj_n, load is
  // raised with inj_d; it is dropped one cycle later unless inj_keep is set.
  task automatic run_bits(input bit sel, input string tag, input logic [3:0] seq,
                          input logic par, input int inj_n, input logic [3:0] inj_d,
                          input bit inj_keep);
    for (int n = 0; n < 4; n++) begin
      check_outs(sel, $sformatf("%s.bit%0d", tag, n), seq[3-n], 1'b1, 1'b0, 1'b0);
      if (n == inj_n) set_load(sel, inj_d, 1'b1);
      if (n == inj_n + 1 && !inj_keep) set_load(sel, 4'h0, 1'b0);
      tick();
    end
`ifdef PISO_PARITY_EN
    check_outs(sel, {tag, ".par"}, par, 1'b1, 1'b0, 1'b0);
    tick();
`else
    if (par === 1'bx) $display("note: parity unused");
`endif
    check_outs(sel, {tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic start(input bit sel, input logic [3:0] d);
    set_load(sel, d, 1'b1);
    tick();
    set_load(sel, d, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rs     = 1'b0;
    din_m  = 4'h0; din_l  = 4'h0;
    load_m = 1'b0; load_l = 1'b0;

    // Reset held for two cycles
    tick();
    tick();
    check_outs(0, "rst_m", 1'b0, 1'b0, 1'b1, 1'b0);
    check_outs(1, "rst_l", 1'b0, 1'b0, 1'b1, 1'b0);
    rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs(0, "idle", 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // MSB first, 1011 -> 1,0,1,1 ; parity 1
    start(0, 4'b1011);
    run_bits(0, "msb1011", 4'b1011, 1'b1, -1, 4'h0, 1'b0);
    tick();
    check_outs(0, "msb1011.after", 1'b0, 1'b0, 1'b1, 1'b0);

    // LSB first, 1011 -> 1,1,0,1 ; mid-frame load of 0000 ignored
    start(1, 4'b1011);
    run_bits(1, "lsb1011", 4'b1101, 1'b1, 2, 4'b0000, 1'b0);
    tick();
    check_outs(1, "lsb1011.after", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs(1, "lsb.noqueue", 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: 1100 then 0011 held from bit 1 until accepted
    start(0, 4'b1100);
    run_bits(0, "b2b_a", 4'b1100, 1'b0, 1, 4'b0011, 1'b1);
    tick();
    set_load(0, 4'h0, 1'b0);
    run_bits(0, "b2b_b", 4'b0011, 1'b0, -1, 4'h0, 1'b0);
    tick();
    check_outs(0, "b2b.after", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during bit 2 of 1111
    start(0, 4'b1111);
    tick();
    tick();
    check_outs(0, "mid.bit2", 1'b1, 1'b1, 1'b0, 1'b0);
    rs = 1'b0;
    #1;
    check_outs(0, "mid.rst", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check({"mid.nodone", $sformatf("%0d", i)}, done_m, 1'b0);
    end
    rs = 1'b1;
    tick();
    check_outs(0, "mid.rel", 1'b0, 1'b0, 1'b1, 1'b0);
    start(0, 4'b0101);
    run_bits(0, "post0101", 4'b0101, 1'b0, -1, 4'h0, 1'b0);
    tick();

`ifdef PISO_PARITY_EN
    start(0, 4'b1001);
    run_bits(0, "par1001", 4'b1001, 1'b0, -1, 4'h0, 1'b0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
